// File: rtl/com_cc_tx.sv
// rtl/com_cc_tx.sv - oversampled serial line transmitter with sync pulse and start/stop framing
// Fixed OSR-clock bit slots after a one-clock sync pulse; words are accepted only at a slot's last phase.
module com_cc_tx #(
  parameter int OSR = 4,
  parameter int DW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fire,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          tx_busy,
  output logic          pin_txd
);

  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BW = $clog2(DW + 2);
  localparam logic [PW-1:0] PH_LAST  = PW'(OSR - 1);
  localparam logic [PW-1:0] PH_PRE   = PW'(OSR - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  typedef enum logic [1:0] {IDLE, SYNC, SLOT} state_t;
  typedef enum logic [1:0] {GAP, START, DATA, STOP} slot_t;

  state_t        state;
  slot_t         slot;
  logic [PW-1:0] phase;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shreg;
  logic          open_slot;
  logic          accept;

  assign open_slot = (slot == GAP) || (slot == STOP);
  // tx_ready is only ever high in the last phase of an open slot, so this is the slot-end accept
  assign accept    = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (rst || !fire) begin
      state    <= IDLE;
      slot     <= GAP;
      phase    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      pin_txd  <= 1'b0;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= SYNC;
          pin_txd <= 1'b1;
        end
        SYNC: begin
          state   <= SLOT;
          slot    <= GAP;
          phase   <= '0;
          pin_txd <= 1'b0;
        end
        SLOT: begin
          // registered, so raise it one phase early to land on the slot's last phase
          tx_ready <= open_slot && (phase == PH_PRE);
          if (phase != PH_LAST) begin
            phase <= phase + 1'b1;
          end else begin
            phase <= '0;
            case (slot)
              GAP, STOP: begin
                if (accept) begin
                  slot    <= START;
                  shreg   <= tx_data;
                  pin_txd <= 1'b1;
                  tx_busy <= 1'b1;
                end else begin
                  slot    <= GAP;
                  pin_txd <= 1'b0;
                  tx_busy <= 1'b0;
                end
              end
              START: begin
                slot    <= DATA;
                bit_cnt <= '0;
                pin_txd <= shreg[0];
                shreg   <= shreg >> 1;
              end
              DATA: begin
                if (bit_cnt == BIT_LAST) begin
                  slot    <= STOP;
                  pin_txd <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  pin_txd <= shreg[0];
                  shreg   <= shreg >> 1;
                end
              end
              default: slot <= GAP;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_com_cc_tx.sv
// tb/tb_com_cc_tx.sv - bench for com_cc_tx: vector table, framed-word sequences, random traffic vs slot-queue model
module tb_com_cc_tx;
  localparam int OSR = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst, fire, tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready, tx_busy, pin_txd;

  int n_cmp = 0;
  int n_bad = 0;

  com_cc_tx #(.OSR(OSR), .DW(DW)) dut (
    .clk(clk), .rst(rst), .fire(fire), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .pin_txd(pin_txd)
  );

  always #5 clk = ~clk;

  // model: line is a stream of slots; an accepted word appends start, data, stop slots
  typedef struct packed { logic v; logic open; logic busy; } mslot_t;
  mslot_t m_q[$];
  mslot_t m_cur = '{1'b0, 1'b1, 1'b0};
  int     m_k = -1;   // -1 link down, 0 sync cycle, k>=1 cycle k-1 of slotted time
  bit     m_acc = 0;

  function automatic void m_exp(output logic p, output logic r, output logic b);
    if (m_k < 0) begin p = 0; r = 0; b = 0; end
    else if (m_k == 0) begin p = 1; r = 0; b = 0; end
    else begin
      p = m_cur.v;
      r = m_cur.open && (((m_k - 1) % OSR) == OSR - 1);
      b = m_cur.busy;
    end
  endfunction

  function automatic void model_step();
    logic p, r, b;
    m_exp(p, r, b);
    m_acc = 0;
    if (rst || !fire) begin
      m_k = -1; m_q.delete(); m_cur = '{1'b0, 1'b1, 1'b0};
    end else if (m_k < 0) begin
      m_k = 0;
    end else begin
      if (r && tx_valid) begin
        m_acc = 1;
        m_q.push_back('{1'b1, 1'b0, 1'b1});
        for (int i = 0; i < DW; i++) m_q.push_back('{tx_data[i], 1'b0, 1'b1});
        m_q.push_back('{1'b0, 1'b1, 1'b1});
      end
      m_k++;
      if (((m_k - 1) % OSR) == 0) m_cur = (m_q.size() > 0) ? m_q.pop_front() : '{1'b0, 1'b1, 1'b0};
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic ep, er, eb;
    model_step();
    @(posedge clk);
    #1;
    m_exp(ep, er, eb);
    check("model_pin", pin_txd, ep);
    check("model_ready", tx_ready, er);
    check("model_busy", tx_busy, eb);
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (tx_ready) ok = 1;
      else step();
    end
    check("wait_ready", ok, 1);
  endtask

  function automatic logic slot_bit(input logic [DW-1:0] w, input int s);
    if (s == 0) return 1'b1;
    if (s <= DW) return w[s-1];
    return 1'b0;
  endfunction

  typedef struct {
    logic rst; logic fire; logic pin; logic rdy; logic busy;
  } vec_t;
  vec_t vecs[15];

  initial begin
    int busy_cnt, pin_bad, rdy_cnt;
    logic [DW-1:0] w;
    rst = 1; fire = 1; tx_valid = 0; tx_data = '0;

    vecs[0]  = '{1, 1, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 0};   // sync pulse
    vecs[4]  = '{0, 1, 0, 0, 0};   // slot 0 phase 0
    vecs[5]  = '{0, 1, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 1, 0};   // slot 0 phase 3
    vecs[8]  = '{0, 1, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 0};
    vecs[11] = '{0, 1, 0, 1, 0};
    vecs[12] = '{0, 0, 0, 0, 0};   // link down
    vecs[13] = '{0, 1, 1, 0, 0};   // fresh sync
    vecs[14] = '{0, 1, 0, 0, 0};
    foreach (vecs[i]) begin
      rst = vecs[i].rst; fire = vecs[i].fire;
      step();
      check($sformatf("vec%0d_pin", i), pin_txd, vecs[i].pin);
      check($sformatf("vec%0d_ready", i), tx_ready, vecs[i].rdy);
      check($sformatf("vec%0d_busy", i), tx_busy, vecs[i].busy);
    end

    // single word 0xA5
    wait_ready();
    w = 8'hA5; tx_data = w; tx_valid = 1;
    step();
    tx_valid = 0; tx_data = 8'h00;
    busy_cnt = 0; pin_bad = 0;
    for (int i = 0; i < 44; i++) begin
      if (tx_busy) busy_cnt++;
      if (i < 40 && pin_txd !== slot_bit(w, i / OSR)) pin_bad++;
      step();
    end
    check("a5_pin_errors", pin_bad, 0);
    check("a5_busy_cycles", busy_cnt, 40);

    // back-to-back 0x00 then 0xFF
    wait_ready();
    tx_data = 8'h00; tx_valid = 1;
    step();
    tx_data = 8'hFF;
    busy_cnt = 0; pin_bad = 0; rdy_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      w = (i < 40) ? 8'h00 : 8'hFF;
      if (tx_busy) busy_cnt++;
      if (tx_ready) rdy_cnt++;
      if (pin_txd !== slot_bit(w, (i % 40) / OSR)) pin_bad++;
      step();
      if (i == 39) tx_valid = 0;
    end
    check("b2b_pin_errors", pin_bad, 0);
    check("b2b_busy_cycles", busy_cnt, 80);
    check("b2b_ready_pulses", rdy_cnt, 2);
    for (int i = 0; i < 6; i++) step();

    // abort during data bit 3 of 0x3C
    wait_ready();
    tx_data = 8'h3C; tx_valid = 1;
    step();
    tx_valid = 0;
    for (int i = 0; i < 17; i++) step();
    fire = 0;
    step();
    check("abort_pin", pin_txd, 0);
    check("abort_busy", tx_busy, 0);
    check("abort_ready", tx_ready, 0);
    fire = 1;
    step();
    check("resync_pin", pin_txd, 1);
    step();
    check("resync_gap_pin", pin_txd, 0);
    check("resync_gap_busy", tx_busy, 0);
    wait_ready();
    tx_data = 8'h5A; tx_valid = 1;
    step();
    tx_valid = 0;
    for (int i = 0; i < 44; i++) step();

    // mid-frame reset
    wait_ready();
    tx_data = 8'h96; tx_valid = 1;
    step();
    tx_valid = 0;
    for (int i = 0; i < 10; i++) step();
    rst = 1;
    step();
    check("rst_pin", pin_txd, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_ready", tx_ready, 0);
    rst = 0;
    step();
    check("rst_sync_pin", pin_txd, 1);
    step();
    check("rst_gap_pin", pin_txd, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if (!tx_valid || m_acc) begin
        tx_valid = ($urandom_range(0, 2) == 0);
        tx_data  = DW'($urandom);
      end
      fire = ($urandom_range(0, 299) != 0);
      rst  = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/com_cc_tx.md
Name: com_cc_tx

Overview:
- Serial line transmitter: the transmit-side counterpart of the team's 4x-oversampled, majority-vote line receiver.
- Accepts parallel words over a valid/ready handshake and drives one serial pin.
- Line format: a single-clock sync pulse, then contiguous bit slots of OSR clocks each. Each frame is a start bit (1), DW data bits LSB first, then a stop bit (0).
- Idle slots carry 0. Sits between the USB-side command logic and the pin.

Parameters:
OSR, 4, clocks per bit slot; must be >= 3 so a 3-sample majority-vote receiver sees stable samples
DW, 8, data word width in bits

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
fire  input  1  link enable; low = link held down, line low
tx_data  input  DW  word to send; captured on accept
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word this cycle
tx_busy  output  1  a frame is in flight (accept through end of stop slot)
pin_txd  output  1  serial line, registered

Behaviour:
- Reset/disable
  - rst is synchronous, active-high, one clock (clk); it dominates fire.
  - On rst, or on fire sampled low: state=IDLE, pin_txd=0, tx_ready=0, tx_busy=0, phase=0, bit count=0, shift register=0.
- States: IDLE, SYNC, SLOT.
- IDLE
  - If fire=1 at edge t: go to SYNC; pin_txd=1 for exactly one cycle after edge t.
- SYNC
  - Unconditionally go to SLOT.
  - Slot 0 begins the next cycle; the phase counter starts at 0.
- SLOT
  - Phase counter runs 0..OSR-1 and wraps. Slot boundaries are fixed forever after sync and never drift or stretch.
  - pin_txd changes only on entry to phase 0 and holds for the OSR cycles of the slot.
- Frame engine
  - Sub-states within SLOT: GAP, START, DATA, STOP.
  - GAP slot drives 0.
  - START drives 1.
  - DATA slot i drives the captured word bit i, i=0..DW-1, LSB first.
  - STOP drives 0.
- Handshake
  - tx_ready=1 only in SLOT, phase==OSR-1, when the current slot is GAP or STOP. It is 0 in every other cycle.
  - Accept = tx_valid & tx_ready. On accept, tx_data is latched into the shift register, and the next slot is START.
  - With no accept, the next slot after STOP or GAP is GAP.
  - Back-to-back frames: if tx_valid is held, START follows STOP directly. There is exactly one stop slot between frames, giving DW+2 slots per frame.
  - The first frame after sync can start no earlier than slot 1, because slot 0 is always GAP.
  - tx_data changes after accept have no effect on the frame in flight.
  - tx_valid without tx_ready is held off with no loss; the upstream keeps tx_data stable.
- tx_busy
  - Set on the cycle after accept; cleared at the end of the last cycle of the stop slot.
  - Remains 1 across back-to-back frames.
- Abort
  - fire low at any point, including mid-frame or in SYNC, returns the block to IDLE on the next edge: pin_txd=0, tx_ready=0, tx_busy=0.
  - The in-flight word is dropped and not retried.
  - When fire is reasserted, a new sync pulse is sent.
- Counters
  - Phase width: clog2(OSR).
  - Bit index width: clog2(DW+2).
  - Both wrap only as defined above; there is no other overflow case.

Test Plan:
- Hold rst=1 with fire=1 for 3 clocks -> pin_txd=0, tx_ready=0, tx_busy=0 every cycle. Release rst with fire=1 -> single-cycle pin_txd=1 pulse, then 0.
- Idle link after sync, tx_valid=0 -> pin_txd stays 0. tx_ready pulses for exactly 1 clock every 4 clocks, on phase 3, beginning in slot 0.
- Send 0xA5 (DW=8, OSR=4) -> after the accept slot, pin_txd holds each of 1,1,0,1,0,0,1,0,1,0 for 4 clocks (start, LSB-first data, stop), 40 clocks total. tx_busy is high for exactly those 40 clocks.
- Back-to-back: present 0x00 then 0xFF with tx_valid held -> second start bit immediately follows the first stop slot, 20 slots total. tx_busy is continuous. tx_ready is seen high exactly once per frame, in its stop or gap slot.
- Abort: drop fire during data bit 3 of 0x3C -> next cycle pin_txd=0, tx_busy=0, tx_ready=0. Reassert fire -> new 1-cycle sync pulse, then slot 0 = GAP; a new word is transmitted cleanly.
- Mid-frame rst=1 for 1 clock, with fire high -> all outputs are at reset values the next cycle. After rst falls, a sync pulse follows, then normal slots.
